// File: rtl/mc_sreq_injector_pkg.sv
// Shared types and default widths for the master-side send-request injector.
// Width helpers keep derived widths consistent between the top and its users.
package mc_sreq_injector_pkg;

  localparam int MC_FIFO_DEPTH         = 32;
  localparam int MC_LOG2_FIFO_DEPTH    = 5;
  localparam int MC_DATA_LINE_WIDTH    = 40;
  localparam int MC_CONTROL_LINE_WIDTH = 0;
  localparam int MC_FLIT_W             = MC_DATA_LINE_WIDTH + MC_CONTROL_LINE_WIDTH;
  localparam int MC_CREDIT_W           = MC_LOG2_FIFO_DEPTH + 1;
  localparam int MC_FLIT_CNT_W         = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } inj_state_e;

  function automatic int flit_width(input int data_w, input int ctrl_w);
    return data_w + ctrl_w;
  endfunction

  function automatic int credit_width(input int log2_depth);
    return log2_depth + 1;
  endfunction

endpackage

// File: rtl/mc_sreq_injector_credit_counter.sv
// Up/down credit counter starting full at DEPTH, saturating at DEPTH with a
// sticky error flag when a return arrives while already full.
module mc_sreq_injector_credit_counter #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_take,
  input  logic             i_return,
  output logic [CNT_W-1:0] o_count,
  output logic             o_err
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  // A simultaneous take and return cancels out, so only the one-sided cases move the count.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    case ({i_take, i_return})
      2'b10: begin
        if (count_q != '0) count_d = count_q - ONE;
      end
      2'b01: begin
        if (count_q == FULL) err_d = 1'b1;
        else                 count_d = count_q + ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= FULL;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign o_count = count_q;
  assign o_err   = err_q;

endmodule

// File: rtl/mc_sreq_injector.sv
// Master-side request injector: accepts flits from the master core, frames packets,
// tracks downstream credits and writes the send-request FIFO one cycle after acceptance.
module mc_sreq_injector
  import mc_sreq_injector_pkg::*;
#(
  parameter  int FIFO_DEPTH         = MC_FIFO_DEPTH,
  parameter  int LOG2_FIFO_DEPTH    = MC_LOG2_FIFO_DEPTH,
  parameter  int DATA_LINE_WIDTH    = MC_DATA_LINE_WIDTH,
  parameter  int CONTROL_LINE_WIDTH = MC_CONTROL_LINE_WIDTH,
  parameter  int MAX_PKT_FLITS      = 4,
  parameter  int WORMHOLE           = 1,
  localparam int FLIT_W             = flit_width(DATA_LINE_WIDTH, CONTROL_LINE_WIDTH),
  localparam int CREDIT_W           = credit_width(LOG2_FIFO_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_mc_valid,
  input  logic [FLIT_W-1:0]   i_mc_bits,
  input  logic                i_mc_last,
  output logic                o_mc_ready,
  output logic [FLIT_W-1:0]   o_sreq_inbits,
  output logic                o_sreq_wen,
  input  logic                i_sreq_fifo_full,
  input  logic                i_credit_ret,
  output logic [CREDIT_W-1:0] o_credits,
  output logic                o_busy,
  output logic [15:0]         o_pkt_count,
  output logic                o_credit_err,
  output logic                o_len_err
);

  localparam logic [CREDIT_W-1:0]      MAX_PKT_CREDITS = CREDIT_W'(MAX_PKT_FLITS);
  localparam logic [MC_FLIT_CNT_W-1:0] MAX_PKT_CNT     = MC_FLIT_CNT_W'(MAX_PKT_FLITS);
  localparam logic [MC_FLIT_CNT_W-1:0] FLIT_CNT_SAT    = '1;
  localparam logic [MC_FLIT_CNT_W-1:0] FLIT_CNT_ONE    = MC_FLIT_CNT_W'(1);

  inj_state_e                state_q, state_d;
  logic [CREDIT_W-1:0]       credits;
  logic                      fire;
  logic                      credit_nz;
  logic                      start_ok;
  logic [MC_FLIT_CNT_W-1:0]  flit_cnt_q, flit_cnt_d;
  logic [MC_FLIT_CNT_W-1:0]  flit_num;
  logic                      sreq_wen_q, sreq_wen_d;
  logic [FLIT_W-1:0]         sreq_bits_q, sreq_bits_d;
  logic [15:0]               pkt_count_q, pkt_count_d;
  logic                      len_err_q, len_err_d;

  assign credit_nz = (credits != '0);
  assign start_ok  = (WORMHOLE != 0) ? credit_nz : (credits >= MAX_PKT_CREDITS);
  assign fire      = i_mc_valid & o_mc_ready;

  mc_sreq_injector_credit_counter #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CREDIT_W)
  ) u_credit (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_take   (fire),
    .i_return (i_credit_ret),
    .o_count  (credits),
    .o_err    (o_credit_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fire && !i_mc_last) state_d = PKT;
      PKT:     if (fire &&  i_mc_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Full-packet mode only gates the head; body flits stream as credits allow.
  always_comb begin
    o_mc_ready = 1'b0;
    o_busy     = 1'b0;
    case (state_q)
      IDLE: o_mc_ready = start_ok & ~i_sreq_fifo_full;
      PKT: begin
        o_mc_ready = credit_nz & ~i_sreq_fifo_full;
        o_busy     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (state_q == PKT)
      flit_num = (flit_cnt_q == FLIT_CNT_SAT) ? flit_cnt_q : flit_cnt_q + FLIT_CNT_ONE;
    else
      flit_num = FLIT_CNT_ONE;

    flit_cnt_d  = flit_cnt_q;
    sreq_wen_d  = fire;
    sreq_bits_d = fire ? i_mc_bits : sreq_bits_q;
    pkt_count_d = pkt_count_q;
    len_err_d   = len_err_q;

    if (fire) begin
      if (i_mc_last) begin
        flit_cnt_d  = '0;
        pkt_count_d = pkt_count_q + 16'd1;
      end else begin
        flit_cnt_d  = flit_num;
      end
      if ((WORMHOLE == 0) && (flit_num > MAX_PKT_CNT)) len_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_cnt_q  <= '0;
      sreq_wen_q  <= 1'b0;
      sreq_bits_q <= '0;
      pkt_count_q <= '0;
      len_err_q   <= 1'b0;
    end else begin
      flit_cnt_q  <= flit_cnt_d;
      sreq_wen_q  <= sreq_wen_d;
      sreq_bits_q <= sreq_bits_d;
      pkt_count_q <= pkt_count_d;
      len_err_q   <= len_err_d;
    end
  end

  assign o_sreq_wen    = sreq_wen_q;
  assign o_sreq_inbits = sreq_bits_q;
  assign o_pkt_count   = pkt_count_q;
  assign o_len_err     = len_err_q;
  assign o_credits     = credits;

endmodule

// File: tb/tb_mc_sreq_injector.sv
// Directed bench for mc_sreq_injector: one wormhole instance (a_*) and one
// full-packet instance (b_*), checked with immediate assertions.
module tb_mc_sreq_injector;

  logic        clk;
  logic        rst_n;

  logic        a_valid, a_last, a_ready, a_wen, a_full, a_ret, a_busy, a_cerr, a_lerr;
  logic [39:0] a_bits, a_inbits;
  logic [5:0]  a_credits;
  logic [15:0] a_pkts;

  logic        b_valid, b_last, b_ready, b_wen, b_full, b_ret, b_busy, b_cerr, b_lerr;
  logic [39:0] b_bits, b_inbits;
  logic [5:0]  b_credits;
  logic [15:0] b_pkts;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  mc_sreq_injector #(.WORMHOLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_mc_valid(a_valid), .i_mc_bits(a_bits), .i_mc_last(a_last), .o_mc_ready(a_ready),
    .o_sreq_inbits(a_inbits), .o_sreq_wen(a_wen), .i_sreq_fifo_full(a_full),
    .i_credit_ret(a_ret), .o_credits(a_credits), .o_busy(a_busy),
    .o_pkt_count(a_pkts), .o_credit_err(a_cerr), .o_len_err(a_lerr)
  );

  mc_sreq_injector #(.WORMHOLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_mc_valid(b_valid), .i_mc_bits(b_bits), .i_mc_last(b_last), .o_mc_ready(b_ready),
    .o_sreq_inbits(b_inbits), .o_sreq_wen(b_wen), .i_sreq_fifo_full(b_full),
    .i_credit_ret(b_ret), .o_credits(b_credits), .o_busy(b_busy),
    .o_pkt_count(b_pkts), .o_credit_err(b_cerr), .o_len_err(b_lerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge so registered outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b1;
    a_valid = 1'b0; a_last = 1'b0; a_bits = '0; a_full = 1'b0; a_ret = 1'b0;
    b_valid = 1'b0; b_last = 1'b0; b_bits = '0; b_full = 1'b0; b_ret = 1'b0;
    #2 rst_n = 1'b0;
    step();
    step();

    check("rst_credits", a_credits, 6'd32);
    check("rst_wen",     a_wen,     1'b0);
    check("rst_bits",    a_inbits,  40'h0);
    check("rst_pkts",    a_pkts,    16'd0);
    check("rst_cerr",    a_cerr,    1'b0);
    check("rst_lerr",    b_lerr,    1'b0);
    check("rst_b_credits", b_credits, 6'd32);
    rst_n = 1'b1;
    step();
    check("idle_ready",  a_ready,   1'b1);
    check("idle_wen",    a_wen,     1'b0);
    check("idle_busy",   a_busy,    1'b0);

    // Wormhole 4-flit packet, back to back
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1;
      a_bits  = 40'hA0 + 40'(i);
      a_last  = (i == 3);
      #1;
      check($sformatf("pkt4_ready%0d", i), a_ready, 1'b1);
      step();
      check($sformatf("pkt4_wen%0d", i),  a_wen,     1'b1);
      check($sformatf("pkt4_bits%0d", i), a_inbits,  40'hA0 + 40'(i));
      check($sformatf("pkt4_busy%0d", i), a_busy,    (i != 3));
      check($sformatf("pkt4_cred%0d", i), a_credits, 6'(31 - i));
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
    step();
    check("pkt4_wen_after",  a_wen,     1'b0);
    check("pkt4_bits_hold",  a_inbits,  40'hA3);
    check("pkt4_pkts",       a_pkts,    16'd1);
    check("pkt4_credits",    a_credits, 6'd28);

    // Drain the remaining 28 credits with single-flit packets
    a_valid = 1'b1;
    a_last  = 1'b1;
    for (int i = 0; i < 28; i++) begin
      a_bits = 40'h100 + 40'(i);
      step();
    end
    check("drain_credits", a_credits, 6'd0);
    check("drain_pkts",    a_pkts,    16'd29);
    check("drain_ready",   a_ready,   1'b0);
    a_bits = 40'h555;
    step();
    check("drain_stall_wen", a_wen, 1'b0);
    a_ret = 1'b1;
    step();
    a_ret = 1'b0;
    check("ret_credits", a_credits, 6'd1);
    check("ret_ready",   a_ready,   1'b1);
    step();
    check("ret_fire_wen",  a_wen,     1'b1);
    check("ret_fire_bits", a_inbits,  40'h555);
    check("ret_fire_cred", a_credits, 6'd0);
    check("ret_fire_pkts", a_pkts,    16'd30);

    // Fire and return in the same cycle keep the count
    a_valid = 1'b0;
    a_ret   = 1'b1;
    step();
    check("pre_both_cred", a_credits, 6'd1);
    a_valid = 1'b1;
    a_bits  = 40'h777;
    step();
    check("both_cred", a_credits, 6'd1);
    check("both_wen",  a_wen,     1'b1);
    check("both_pkts", a_pkts,    16'd31);

    // Return credits up to full, then one too many
    a_valid = 1'b0;
    a_last  = 1'b0;
    for (int i = 0; i < 31; i++) step();
    check("refill_credits", a_credits, 6'd32);
    check("refill_cerr",    a_cerr,    1'b0);
    step();
    a_ret = 1'b0;
    check("over_credits", a_credits, 6'd32);
    check("over_cerr",    a_cerr,    1'b1);
    step();
    check("cerr_sticky",  a_cerr,    1'b1);

    // Send FIFO full blocks acceptance
    a_full  = 1'b1;
    a_valid = 1'b1;
    a_last  = 1'b1;
    #1;
    check("full_ready", a_ready, 1'b0);
    step();
    check("full_wen",   a_wen,   1'b0);
    a_full  = 1'b0;
    a_valid = 1'b0;

    // Full-packet mode: drop to 3 credits, head must wait
    b_valid = 1'b1;
    b_last  = 1'b1;
    for (int i = 0; i < 29; i++) begin
      b_bits = 40'h200 + 40'(i);
      step();
    end
    check("b_drain_credits", b_credits, 6'd3);
    check("b_drain_pkts",    b_pkts,    16'd29);
    b_bits = 40'hBEEF;
    b_last = 1'b0;
    #1;
    check("b_three_ready", b_ready, 1'b0);
    step();
    check("b_three_wen",   b_wen,   1'b0);
    b_ret = 1'b1;
    step();
    b_ret = 1'b0;
    check("b_four_credits", b_credits, 6'd4);
    check("b_four_ready",   b_ready,   1'b1);
    step();
    check("b_head_wen",  b_wen,    1'b1);
    check("b_head_bits", b_inbits, 40'hBEEF);
    check("b_head_busy", b_busy,   1'b1);
    // Finish that packet with a tail flit, then refill credits
    b_bits = 40'hBEF0;
    b_last = 1'b1;
    step();
    b_valid = 1'b0;
    b_last  = 1'b0;
    check("b_tail_busy", b_busy,    1'b0);
    check("b_tail_pkts", b_pkts,    16'd30);
    check("b_tail_cred", b_credits, 6'd2);
    b_ret = 1'b1;
    for (int i = 0; i < 30; i++) step();
    b_ret = 1'b0;
    check("b_refill", b_credits, 6'd32);

    // Six-flit packet overruns MAX_PKT_FLITS on the fifth flit
    for (int i = 0; i < 6; i++) begin
      b_valid = 1'b1;
      b_bits  = 40'hC0 + 40'(i);
      b_last  = (i == 5);
      step();
      check($sformatf("b6_wen%0d", i),  b_wen,    1'b1);
      check($sformatf("b6_bits%0d", i), b_inbits, 40'hC0 + 40'(i));
      check($sformatf("b6_lerr%0d", i), b_lerr,   (i >= 4));
    end
    b_valid = 1'b0;
    b_last  = 1'b0;
    step();
    check("b6_wen_after", b_wen,     1'b0);
    check("b6_pkts",      b_pkts,    16'd31);
    check("b6_credits",   b_credits, 6'd26);
    check("b6_a_lerr",    a_lerr,    1'b0);

    // Reset in the middle of a packet
    a_valid = 1'b1;
    a_last  = 1'b0;
    a_bits  = 40'hD0;
    step();
    check("mid_head_wen",  a_wen,  1'b1);
    check("mid_head_busy", a_busy, 1'b1);
    a_bits = 40'hD1;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_wen",  a_wen,     1'b0);
    check("mid_rst_busy", a_busy,    1'b0);
    check("mid_rst_cred", a_credits, 6'd32);
    check("mid_rst_bits", a_inbits,  40'h0);
    check("mid_rst_cerr", a_cerr,    1'b0);
    a_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_wen",  a_wen,  1'b0);
    check("post_rst_pkts", a_pkts, 16'd0);
    check("post_rst_lerr", b_lerr, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
